// File: rtl/perif_bus_responder.sv
// Peripheral-window bus target: 8 GPIO/display regs plus a prescaled 64-bit timer with compare/irq.
// Reads are combinational (zero latency), writes land on the clock edge; the CPU is never stalled.
module perif_bus_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int NREG   = 8,
  parameter int REG_W  = 16,
  parameter int DIV    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  mem_read,
  input  logic                  mem_write_en,
  input  logic [1:0]            size,
  input  logic [ADDR_W-1:0]     address,
  inout  wire  [DATA_W-1:0]     data,
  output logic                  irq,
  output logic [NREG*REG_W-1:0] regs_flat
);
  localparam logic [3:0] OFF_TIMER  = 4'd8;
  localparam logic [3:0] OFF_STATUS = 4'd9;
  localparam logic [3:0] OFF_CMP    = 4'd10;
  localparam logic [3:0] OFF_CTRL   = 4'd11;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int RIW = $clog2(NREG);

  logic [REG_W-1:0]  r [NREG];
  logic [DATA_W-1:0] timer;
  logic [DATA_W-1:0] compare;
  logic              status;
  logic [2:0]        ctrl;
  logic [PW-1:0]     presc;

  logic [3:0]        off;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] cur_val;
  logic [DATA_W-1:0] wr_merged;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] timer_inc;
  logic              wr_en;
  logic              bus_drive;
  logic              is_reg;
  logic              tick;
  logic              timer_wr;
  logic              match;
  logic              unused_addr;

  assign off         = address[6:3];
  assign unused_addr = ^{address[ADDR_W-1:7], address[2:0]};
  assign wr_en       = cs & mem_write_en;
  assign bus_drive   = reset & cs & mem_read & ~mem_write_en;
  assign is_reg      = (off < 4'(NREG));

  always_comb begin
    case (size)
      2'b00:   mask = DATA_W'(64'h0000_0000_0000_00FF);
      2'b01:   mask = DATA_W'(64'h0000_0000_0000_FFFF);
      2'b10:   mask = DATA_W'(64'h0000_0000_FFFF_FFFF);
      default: mask = {DATA_W{1'b1}};
    endcase
  end

  // Current value of the addressed target, shared by the read path and the byte-lane merge.
  always_comb begin
    cur_val = '0;
    if (is_reg) begin
      cur_val = DATA_W'(r[off[RIW-1:0]]);
    end else begin
      case (off)
        OFF_TIMER:  cur_val = timer;
        OFF_STATUS: cur_val = DATA_W'(status);
        OFF_CMP:    cur_val = compare;
        OFF_CTRL:   cur_val = DATA_W'(ctrl);
        default:    cur_val = '0;
      endcase
    end
  end

  assign wr_merged = (cur_val & ~mask) | (data & mask);
  assign rd_val    = cur_val & mask;
  assign data      = bus_drive ? rd_val : {DATA_W{1'bz}};

  assign timer_inc = timer + DATA_W'(1);
  assign tick      = ctrl[0] & (presc == PW'(DIV - 1));
  assign timer_wr  = wr_en & (off == OFF_TIMER);
  // A CPU write to TIMER suppresses both the increment and any match on that edge.
  assign match     = tick & ~timer_wr & (timer_inc == compare);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) r[i] <= '0;
      timer   <= '0;
      compare <= '1;
      status  <= 1'b0;
      ctrl    <= '0;
      presc   <= '0;
    end else begin
      if (ctrl[0]) presc <= tick ? '0 : presc + PW'(1);

      if (timer_wr)   timer <= wr_merged;
      else if (tick)  timer <= (match && ctrl[1]) ? '0 : timer_inc;

      if (match)                                       status <= 1'b1;
      else if (wr_en && off == OFF_STATUS && data[0])  status <= 1'b0;

      if (wr_en && off == OFF_CMP)  compare <= wr_merged;
      if (wr_en && off == OFF_CTRL) ctrl    <= wr_merged[2:0];
      if (wr_en && is_reg)          r[off[RIW-1:0]] <= wr_merged[REG_W-1:0];
    end
  end

  assign irq = status & ctrl[2];

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign regs_flat[g*REG_W +: REG_W] = r[g];
  end

endmodule

// File: tb/tb_perif_bus_responder.sv
// Directed bench with a register-level reference model checked every cycle, plus literal pins.
module tb_perif_bus_responder;
  localparam int DIV = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         cs = 1'b0;
  logic         mem_read = 1'b0;
  logic         mem_write_en = 1'b0;
  logic [1:0]   size = 2'b00;
  logic [31:0]  address = '0;
  logic         wr_drive = 1'b0;
  logic [63:0]  wr_val = '0;
  wire  [63:0]  data;
  logic         irq;
  logic [127:0] regs_flat;
  logic [63:0]  rv;

  int n_cmp = 0;
  int n_fail = 0;

  assign data = wr_drive ? wr_val : {64{1'bz}};

  perif_bus_responder #(
    .ADDR_W(32), .DATA_W(64), .NREG(8), .REG_W(16), .DIV(DIV)
  ) dut (
    .clock(clock), .reset(reset), .cs(cs), .mem_read(mem_read),
    .mem_write_en(mem_write_en), .size(size), .address(address),
    .data(data), .irq(irq), .regs_flat(regs_flat)
  );

  always #5 clock = ~clock;

  // Reference model: architectural register state plus a count of enabled clocks.
  logic [15:0] m_r [8];
  logic [63:0] m_timer, m_cmp;
  logic        m_status;
  logic [2:0]  m_ctrl;
  int          m_en_cnt;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] bmask(input logic [1:0] sz);
    logic [63:0] m;
    m = '0;
    for (int b = 0; b < (1 << sz); b++) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = '0;
    m_timer = '0; m_cmp = '1; m_status = 1'b0; m_ctrl = '0; m_en_cnt = 0;
  endfunction

  function automatic logic [63:0] mread(input int off, input logic [1:0] sz);
    logic [63:0] v;
    v = '0;
    if (off < 8)        v = {48'b0, m_r[off]};
    else if (off == 8)  v = m_timer;
    else if (off == 9)  v = {63'b0, m_status};
    else if (off == 10) v = m_cmp;
    else if (off == 11) v = {61'b0, m_ctrl};
    return v & bmask(sz);
  endfunction

  function automatic void model_step();
    logic [63:0] mk, nv;
    int  off;
    bit  wr, bump, hit;
    wr   = cs && mem_write_en;
    off  = int'(address[6:3]);
    mk   = bmask(size);
    bump = 1'b0;
    hit  = 1'b0;
    if (m_ctrl[0]) begin
      m_en_cnt++;
      bump = (m_en_cnt % DIV) == 0;
    end
    if (bump && !(wr && off == 8)) begin
      nv = m_timer + 64'd1;
      if (nv == m_cmp) begin
        hit = 1'b1;
        if (m_ctrl[1]) nv = '0;
      end
      m_timer = nv;
    end
    if (wr) begin
      nv = (mread(off, 2'b11) & ~mk) | (wr_val & mk);
      if (off < 8)        m_r[off] = nv[15:0];
      else if (off == 8)  m_timer = nv;
      else if (off == 9)  begin if (wr_val[0]) m_status = 1'b0; end
      else if (off == 10) m_cmp = nv;
      else if (off == 11) m_ctrl = nv[2:0];
    end
    if (hit) m_status = 1'b1;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) model_reset();
    else        model_step();
  end

  always @(negedge clock) begin
    logic [127:0] exp_flat;
    for (int i = 0; i < 8; i++) exp_flat[i*16 +: 16] = m_r[i];
    check("regs_flat", regs_flat, exp_flat);
    check("irq", {127'b0, irq}, {127'b0, m_status & m_ctrl[2]});
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [1:0] sz, input logic [63:0] v);
    address = a; size = sz; cs = 1'b1; mem_write_en = 1'b1; mem_read = 1'b0;
    wr_drive = 1'b1; wr_val = v;
    @(posedge clock); #1;
    cs = 1'b0; mem_write_en = 1'b0; wr_drive = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [1:0] sz, input string name,
                          output logic [63:0] v);
    address = a; size = sz; cs = 1'b1; mem_read = 1'b1; mem_write_en = 1'b0; wr_drive = 1'b0;
    #1;
    check({name, " drive"}, {127'b0, dut.bus_drive}, 128'd1);
    v = data;
    check(name, {64'b0, v}, {64'b0, mread(int'(a[6:3]), sz)});
    cs = 1'b0; mem_read = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    idle(2);
    check("reset regs", regs_flat, 128'd0);
    check("reset irq", {127'b0, irq}, 128'd0);
    reset = 1'b1;
    idle(1);

    // Byte-lane sizes on R2
    bus_write(32'h10, 2'b11, 64'h1122_3344_5566_7788);
    check("R2 dword trunc", {112'b0, regs_flat[47:32]}, {112'b0, 16'h7788});
    bus_write(32'h10, 2'b00, 64'hFFFF_FFFF_FFFF_FFAB);
    check("R2 byte merge", {112'b0, regs_flat[47:32]}, {112'b0, 16'h77AB});
    bus_read(32'h10, 2'b01, "LDURH R2", rv);
    check("LDURH lit", {64'b0, rv}, {64'b0, 64'h0000_0000_0000_77AB});
    bus_read(32'h13, 2'b00, "LDURB R2", rv);
    check("LDURB lit", {64'b0, rv}, {64'b0, 64'h0000_0000_0000_00AB});
    idle(1);

    // Bus drive rules and unmapped window
    cs = 1'b0; mem_read = 1'b1; address = 32'h10; #1;
    check("cs0 no drive", {127'b0, dut.bus_drive}, 128'd0);
    mem_read = 1'b0;
    idle(1);
    address = 32'h18; size = 2'b01; cs = 1'b1; mem_read = 1'b1; mem_write_en = 1'b1;
    wr_drive = 1'b1; wr_val = 64'h0000_0000_0000_5A5A; #1;
    check("rd+wr no drive", {127'b0, dut.bus_drive}, 128'd0);
    check("rd+wr bus value", {64'b0, data}, {64'b0, 64'h5A5A});
    @(posedge clock); #1;
    cs = 1'b0; mem_read = 1'b0; mem_write_en = 1'b0; wr_drive = 1'b0;
    check("rd+wr is write", {112'b0, regs_flat[63:48]}, {112'b0, 16'h5A5A});
    bus_read(32'h70, 2'b11, "unmapped read", rv);
    check("unmapped lit", {64'b0, rv}, 128'd0);
    bus_write(32'h70, 2'b11, '1);
    bus_read(32'h50, 2'b11, "COMPARE after unmapped wr", rv);
    check("COMPARE lit", {64'b0, rv}, {64'b0, 64'hFFFF_FFFF_FFFF_FFFF});

    // Prescaled timer: 40 enabled clocks at DIV=4, then frozen
    bus_write(32'h58, 2'b00, 64'd1);
    idle(39);
    bus_write(32'h58, 2'b00, 64'd0);
    bus_read(32'h40, 2'b11, "TIMER run", rv);
    check("TIMER=10", {64'b0, rv}, 128'd10);
    idle(20);
    bus_read(32'h40, 2'b11, "TIMER frozen", rv);
    check("TIMER frozen=10", {64'b0, rv}, 128'd10);

    // 64-bit wrap, then CPU write vs increment on the same edge
    bus_write(32'h40, 2'b11, '1);
    bus_write(32'h58, 2'b00, 64'd1);
    idle(4);
    bus_read(32'h40, 2'b11, "TIMER wrap", rv);
    check("TIMER wrap=0", {64'b0, rv}, 128'd0);
    for (int k = 0; k < 8 && (m_en_cnt % DIV) != DIV - 1; k++) idle(1);
    check("phase wait A", m_en_cnt % DIV, DIV - 1);
    bus_write(32'h40, 2'b11, 64'h1234);
    bus_read(32'h40, 2'b11, "TIMER write wins", rv);
    check("TIMER=0x1234", {64'b0, rv}, 128'h1234);
    idle(4);
    bus_read(32'h40, 2'b11, "TIMER +1", rv);
    check("TIMER=0x1235", {64'b0, rv}, 128'h1235);
    for (int k = 0; k < 8 && (m_en_cnt % DIV) != DIV - 1; k++) idle(1);
    check("phase wait B", m_en_cnt % DIV, DIV - 1);
    bus_write(32'h58, 2'b00, 64'd0);

    // Compare match with auto-clear and irq, W1C, match beating W1C
    bus_write(32'h40, 2'b11, 64'd0);
    bus_write(32'h50, 2'b11, 64'd5);
    bus_write(32'h58, 2'b00, 64'b111);
    idle(19);
    check("irq before match", {127'b0, irq}, 128'd0);
    bus_read(32'h40, 2'b11, "TIMER pre-match", rv);
    check("TIMER=4", {64'b0, rv}, 128'd4);
    idle(1);
    check("irq on match", {127'b0, irq}, 128'd1);
    bus_read(32'h40, 2'b11, "TIMER auto-clear", rv);
    check("TIMER=0 after match", {64'b0, rv}, 128'd0);
    bus_write(32'h48, 2'b00, 64'd1);
    check("irq after W1C", {127'b0, irq}, 128'd0);
    idle(18);
    bus_write(32'h48, 2'b00, 64'd1);
    check("match beats W1C", {127'b0, irq}, 128'd1);
    bus_read(32'h48, 2'b00, "STATUS", rv);
    check("STATUS=1", {64'b0, rv}, 128'd1);

    // Asynchronous reset in the middle of a write
    address = 32'h0; size = 2'b11; cs = 1'b1; mem_write_en = 1'b1;
    wr_drive = 1'b1; wr_val = 64'hFFFF;
    #2; reset = 1'b0; #1;
    check("mid-write reset regs", regs_flat, 128'd0);
    check("mid-write reset irq", {127'b0, irq}, 128'd0);
    check("mid-write reset drive", {127'b0, dut.bus_drive}, 128'd0);
    @(posedge clock); #1;
    check("write blocked in reset", regs_flat, 128'd0);
    cs = 1'b0; mem_write_en = 1'b0; wr_drive = 1'b0;
    cs = 1'b1; mem_read = 1'b1; #1;
    check("read in reset no drive", {127'b0, dut.bus_drive}, 128'd0);
    cs = 1'b0; mem_read = 1'b0;
    reset = 1'b1;
    bus_read(32'h58, 2'b11, "CTRL after reset", rv);
    check("CTRL=0", {64'b0, rv}, 128'd0);
    bus_read(32'h40, 2'b11, "TIMER after reset", rv);
    check("TIMER=0 reset", {64'b0, rv}, 128'd0);
    bus_read(32'h50, 2'b10, "COMPARE word after reset", rv);
    check("COMPARE word", {64'b0, rv}, {64'b0, 64'h0000_0000_FFFF_FFFF});
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
